// File: rtl/chime_sequencer.sv
// Hourly/half-hourly chime generator: on a trigger it plays N beeps on the buzzer, and the last
// beep is long and high-toned. Supports mute window and cancel.
module chime_sequencer #(
  parameter int unsigned BEEP_ON_CYC  = 10_000_000,
  parameter int unsigned BEEP_OFF_CYC = 15_000_000,
  parameter int unsigned LAST_ON_CYC  = 25_000_000,
  parameter int unsigned CNT_W        = 26
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [4:0] hour,
  input  logic [5:0] minute,
  input  logic [5:0] second,
  input  logic       sec_tick,
  input  logic       mode_12h,
  input  logic       half_hour_en,
  input  logic       mute_en,
  input  logic [4:0] mute_start,
  input  logic [4:0] mute_end,
  input  logic       cancel,
  output logic       buzz,
  output logic       tone_hi,
  output logic       busy,
  output logic [4:0] beeps_left
);

  localparam logic [CNT_W-1:0] OnEnd   = CNT_W'(BEEP_ON_CYC - 1);
  localparam logic [CNT_W-1:0] OffEnd  = CNT_W'(BEEP_OFF_CYC - 1);
  localparam logic [CNT_W-1:0] LastEnd = CNT_W'(LAST_ON_CYC - 1);

  typedef enum logic [1:0] {StIdle, StOn, StOff} state_e;

  state_e           state_q;
  logic [CNT_W-1:0] cnt_q;

  logic       in_window;
  logic       trig;
  logic [4:0] hour_mod;
  logic [4:0] n_beeps;
  logic       on_done;
  logic       off_done;

  always_comb begin
    hour_mod = (hour >= 5'd12) ? hour - 5'd12 : hour;

    in_window = 1'b0;
    if (mute_start < mute_end) begin
      in_window = (hour >= mute_start) && (hour < mute_end);
    end else if (mute_start > mute_end) begin
      in_window = (hour >= mute_start) || (hour < mute_end);
    end

    if (minute == 6'd30) begin
      n_beeps = 5'd1;
    end else if (mode_12h) begin
      n_beeps = (hour_mod == 5'd0) ? 5'd12 : hour_mod;
    end else begin
      n_beeps = (hour == 5'd0) ? 5'd24 : hour;
    end

    trig = sec_tick && (second == 6'd0) && (hour <= 5'd23) &&
           ((minute == 6'd0) || (half_hour_en && (minute == 6'd30))) &&
           !(mute_en && in_window);

    // Only the final beep (nothing left to start) uses the long duration.
    on_done  = (beeps_left != 5'd0) ? (cnt_q == OnEnd) : (cnt_q == LastEnd);
    off_done = (cnt_q == OffEnd);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= StIdle;
      cnt_q      <= '0;
      buzz       <= 1'b0;
      tone_hi    <= 1'b0;
      busy       <= 1'b0;
      beeps_left <= 5'd0;
    end else if (cancel) begin
      state_q    <= StIdle;
      cnt_q      <= '0;
      buzz       <= 1'b0;
      tone_hi    <= 1'b0;
      busy       <= 1'b0;
      beeps_left <= 5'd0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (trig) begin
            state_q    <= StOn;
            cnt_q      <= '0;
            buzz       <= 1'b1;
            busy       <= 1'b1;
            tone_hi    <= (n_beeps == 5'd1);
            beeps_left <= n_beeps - 5'd1;
          end
        end
        StOn: begin
          if (on_done) begin
            cnt_q <= '0;
            buzz  <= 1'b0;
            if (beeps_left != 5'd0) begin
              state_q <= StOff;
            end else begin
              state_q <= StIdle;
              tone_hi <= 1'b0;
              busy    <= 1'b0;
            end
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        StOff: begin
          if (off_done) begin
            state_q    <= StOn;
            cnt_q      <= '0;
            buzz       <= 1'b1;
            tone_hi    <= (beeps_left == 5'd1);
            beeps_left <= beeps_left - 5'd1;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

endmodule

// File: tb/tb_chime_sequencer.sv
// Self-checking bench for chime_sequencer: a per-cycle timeline model plus directed scenarios.
module tb_chime_sequencer;

  localparam int ON   = 4;
  localparam int OFF  = 3;
  localparam int LAST = 8;
  localparam int P    = ON + OFF;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [4:0] hour;
  logic [5:0] minute, second;
  logic       sec_tick, mode_12h, half_hour_en, mute_en, cancel;
  logic [4:0] mute_start, mute_end;
  logic       buzz, tone_hi, busy;
  logic [4:0] beeps_left;

  int tests = 0;
  int fails = 0;

  chime_sequencer #(
    .BEEP_ON_CYC (ON),
    .BEEP_OFF_CYC(OFF),
    .LAST_ON_CYC (LAST),
    .CNT_W       (4)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .hour        (hour),
    .minute      (minute),
    .second      (second),
    .sec_tick    (sec_tick),
    .mode_12h    (mode_12h),
    .half_hour_en(half_hour_en),
    .mute_en     (mute_en),
    .mute_start  (mute_start),
    .mute_end    (mute_end),
    .cancel      (cancel),
    .buzz        (buzz),
    .tone_hi     (tone_hi),
    .busy        (busy),
    .beeps_left  (beeps_left)
  );

  always #5 clk = ~clk;

  // Timeline model: a sequence is a position k within (n-1)*P + LAST cycles.
  bit m_active;
  int m_k, m_n;

  function automatic bit model_muted(int h, int s, int e, bit en);
    if (!en || s == e) return 1'b0;
    if (s < e) return (h >= s) && (h < e);
    return (h >= s) || (h < e);
  endfunction

  function automatic int model_count(int h, int m, bit m12);
    if (m == 30) return 1;
    if (m12) return (h % 12 == 0) ? 12 : h % 12;
    return (h == 0) ? 24 : h;
  endfunction

  function automatic bit model_trig();
    bit base;
    base = sec_tick && second == 0 && hour <= 23 &&
           (minute == 0 || (half_hour_en && minute == 30));
    return base && !model_muted(int'(hour), int'(mute_start), int'(mute_end), mute_en);
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_active <= 1'b0;
      m_k      <= 0;
      m_n      <= 0;
    end else if (cancel) begin
      m_active <= 1'b0;
    end else if (m_active) begin
      if (m_k + 1 == (m_n - 1) * P + LAST) m_active <= 1'b0;
      else m_k <= m_k + 1;
    end else if (model_trig()) begin
      m_active <= 1'b1;
      m_k      <= 0;
      m_n      <= model_count(int'(hour), int'(minute), mode_12h);
    end
  end

  always @(negedge clk) begin
    if (rst_n) begin
      bit e_buzz, e_tone, e_busy;
      int e_left;
      e_buzz = 0; e_tone = 0; e_busy = m_active; e_left = 0;
      if (m_active) begin
        if (m_k < (m_n - 1) * P) begin
          e_buzz = (m_k % P) < ON;
          e_left = m_n - 1 - m_k / P;
        end else begin
          e_buzz = 1;
          e_tone = 1;
        end
      end
      tests++;
      if (buzz !== e_buzz || tone_hi !== e_tone || busy !== e_busy || int'(beeps_left) != e_left)
      begin
        fails++;
        $display("FAIL model t=%0t got buzz/tone/busy/left=%b%b%b/%0d want %b%b%b/%0d",
                 $time, buzz, tone_hi, busy, beeps_left, e_buzz, e_tone, e_busy, e_left);
      end
    end
  end

  task automatic check(input string name, input int act, input int exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s got %0d want %0d", name, act, exp);
    end
  endtask

  task automatic fire(input int h, input int m, input int s);
    @(negedge clk);
    hour = 5'(h); minute = 6'(m); second = 6'(s); sec_tick = 1'b1;
    @(negedge clk);
    sec_tick = 1'b0;
  endtask

  // Counts busy cycles, buzz rising edges and tone_hi cycles until busy falls or bound runs out.
  task automatic measure(input int bound, output int busy_c, output int beeps, output int tone_c);
    bit seen, prev;
    busy_c = 0; beeps = 0; tone_c = 0; seen = 0; prev = 0;
    for (int i = 0; i < bound; i++) begin
      if (busy) begin busy_c++; seen = 1; end
      if (buzz && !prev) beeps++;
      if (tone_hi) tone_c++;
      prev = buzz;
      if (seen && !busy) break;
      @(negedge clk);
    end
    if (seen && busy) check("timeout", 1, 0);
  endtask

  task automatic chime(input string name, input int h, input int m, input int bound,
                       input int exp_beeps, input int exp_busy, input int exp_tone);
    int bc, bp, tc;
    fire(h, m, 0);
    measure(bound, bc, bp, tc);
    check({name, "_beeps"}, bp, exp_beeps);
    check({name, "_busy"}, bc, exp_busy);
    check({name, "_tone"}, tc, exp_tone);
  endtask

  initial begin
    int cnt;
    rst_n = 0; hour = 0; minute = 1; second = 0; sec_tick = 0; mode_12h = 1;
    half_hour_en = 0; mute_en = 0; mute_start = 0; mute_end = 0; cancel = 0;
    repeat (3) @(negedge clk);
    check("reset_outputs", int'({buzz, tone_hi, busy, beeps_left}), 0);
    rst_n = 1;
    repeat (2) @(negedge clk);

    chime("h15_12h", 15, 0, 400, 3, 22, 8);
    mode_12h = 0;
    chime("h15_24h", 15, 0, 400, 15, 106, 8);
    mode_12h = 1;
    chime("h0_12h", 0, 0, 400, 12, 85, 8);
    mode_12h = 0;
    chime("h0_24h", 0, 0, 400, 24, 169, 8);
    mode_12h = 1;
    chime("h12_12h", 12, 0, 400, 12, 85, 8);

    half_hour_en = 1;
    chime("half_on", 9, 30, 400, 1, 8, 8);
    half_hour_en = 0;
    chime("half_off", 9, 30, 20, 0, 0, 0);

    mute_en = 1; mute_start = 22; mute_end = 6;
    chime("mute_h23", 23, 0, 20, 0, 0, 0);
    chime("mute_h3", 3, 0, 20, 0, 0, 0);
    chime("mute_h6", 6, 0, 400, 6, 43, 8);
    chime("mute_h21", 21, 0, 400, 9, 64, 8);
    mute_start = 5; mute_end = 5;
    chime("mute_eq_h3", 3, 0, 400, 3, 22, 8);
    mute_en = 0;

    // Cancel during the second beep of a 5-beep sequence.
    fire(5, 0, 0);
    repeat (8) @(negedge clk);
    check("cancel_pre_buzz", int'(buzz), 1);
    check("cancel_pre_left", int'(beeps_left), 3);
    cancel = 1;
    @(negedge clk);
    cancel = 0;
    check("cancel_buzz", int'(buzz), 0);
    check("cancel_busy", int'(busy), 0);
    check("cancel_left", int'(beeps_left), 0);
    cnt = 0;
    repeat (60) begin @(negedge clk); if (buzz || busy) cnt++; end
    check("cancel_silent", cnt, 0);

    // Asynchronous reset in the first OFF gap.
    fire(3, 0, 0);
    repeat (5) @(negedge clk);
    check("rst_pre_off", int'({buzz, busy}), 1);
    rst_n = 0;
    #1;
    check("rst_async", int'({buzz, tone_hi, busy, beeps_left}), 0);
    repeat (3) @(negedge clk);
    rst_n = 1;
    cnt = 0;
    repeat (40) begin @(negedge clk); if (buzz || busy) cnt++; end
    check("rst_silent", cnt, 0);

    // Top of the hour without sec_tick, and an out-of-range hour.
    @(negedge clk);
    hour = 4; minute = 0; second = 0;
    cnt = 0;
    repeat (20) begin @(negedge clk); if (busy) cnt++; end
    check("no_tick", cnt, 0);
    minute = 1;
    chime("h25", 25, 0, 20, 0, 0, 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/chime_sequencer.md
# chime_sequencer

Parametrised hourly/half-hourly chime generator for the digital clock. It watches the decimal time from the timekeeping core and, on the hour, drives the buzzer with a train of discrete beeps whose count equals the hour (12 h or 24 h counting), ending with a long high-tone beep. It also supports an optional single half-hour beep, a configurable night mute window, and user cancel. Its outputs feed the buzzer driver, and `busy` goes to the display/UI.

## Interface
Parameters:
- `BEEP_ON_CYC`, default 10_000_000, clk cycles per normal beep (buzz high).
- `BEEP_OFF_CYC`, default 15_000_000, clk cycles of silence between beeps.
- `LAST_ON_CYC`, default 25_000_000, clk cycles of the final (long, high-tone) beep.
- `CNT_W`, default 26, duration counter width; must hold max(BEEP_ON_CYC, BEEP_OFF_CYC, LAST_ON_CYC).

Ports:
- `clk`  in  1  system clock.
- `rst_n`  in  1  asynchronous, active-low reset.
- `hour`  in  5  current hour, 0–23.
- `minute`  in  6  current minute, 0–59.
- `second`  in  6  current second, 0–59.
- `sec_tick`  in  1  one-cycle pulse, asserted in the cycle when hour/minute/second take a new value.
- `mode_12h`  in  1  1: beep count uses the 12 h value; 0: uses the 24 h value.
- `half_hour_en`  in  1  enables a single beep at mm:ss = 30:00.
- `mute_en`  in  1  enables the mute window.
- `mute_start`, `mute_end`  in  5 each  mute window hours; the window is [start, end).
- `cancel`  in  1  level or pulse; aborts the current sequence.
- `buzz`  out  1  buzzer enable.
- `tone_hi`  out  1  high-tone select; 1 only during the final beep of a sequence.
- `busy`  out  1  a sequence is in progress.
- `beeps_left`  out  5  beeps still to start, not counting the one currently sounding.

## Operation
- Trigger is evaluated only in cycles where `sec_tick`=1:
  - Hourly trigger: minute==0, second==0 and hour≤23.
  - Half-hour trigger: half_hour_en, minute==30, second==0 and hour≤23.
  - An hour value >23 never triggers.
- Beep count N for an hourly trigger:
  - mode_12h=1: h%12, with 0 mapped to 12. Range 1–12.
  - mode_12h=0: hour, with 0 mapped to 24. Range 1–24.
  - A half-hour trigger gives N=1.
- Mute: with mute_en=1, a trigger is suppressed when the hour is in the window.
  - start<end: window is start ≤ hour < end.
  - start>end: window wraps midnight, hour ≥ start OR hour < end.
  - start==end: no mute.
- FSM states and transitions:
  - IDLE → ON on trigger. Load beeps_left=N−1 and clear the duration counter.
  - ON: buzz=1. Duration is BEEP_ON_CYC when beeps_left>0, otherwise LAST_ON_CYC with tone_hi=1. At the end of the duration: if beeps_left>0, go to OFF; else go to IDLE.
  - OFF: buzz=0 for BEEP_OFF_CYC cycles, then go to ON and decrement beeps_left.
- A new trigger while busy is ignored. Under normal time flow this cannot happen, since a sequence always finishes in well under 30 min.
- cancel=1 in any state forces IDLE on the next edge: buzz, tone_hi and busy go to 0, and beeps_left goes to 0. A trigger arriving in the same cycle as cancel is dropped.
- `busy` is 1 in ON and OFF.

## Timing
- Reset (asynchronous): state=IDLE, buzz=0, tone_hi=0, busy=0, beeps_left=0, counter=0.
- Latency: buzz rises on the first clk edge after the cycle in which the trigger was sampled.
- Each ON phase holds buzz high for exactly its duration in cycles. Each OFF phase holds buzz low for exactly BEEP_OFF_CYC cycles.
- There is no trailing OFF after the last beep: buzz and busy fall together, and the FSM is in IDLE.
- Total duration for N beeps: (N−1)·(BEEP_ON_CYC+BEEP_OFF_CYC) + LAST_ON_CYC cycles.
- beeps_left decrements on the OFF→ON edge.
- Reset asserted mid-sequence returns to the reset values immediately. After reset is released, nothing sounds until the next trigger.

## Test plan
Bench parameters: BEEP_ON_CYC=4, BEEP_OFF_CYC=3, LAST_ON_CYC=8.
- hour=15, mode_12h=1, 00:00 tick → 3 beeps with buzz high 4, 4, 8 cycles and lows of 3. tone_hi only on the 8-cycle beep. busy is high for 22 cycles. Same test with mode_12h=0 → 15 beeps, 8+14·7=106 cycles.
- hour=0: mode_12h=1 → 12 beeps; mode_12h=0 → 24 beeps. hour=12 with mode_12h=1 → 12 beeps.
- half_hour_en=1, 30:00 tick at hour 9 → a single 8-cycle tone_hi beep. With half_hour_en=0 → nothing.
- Mute window 22→6, mute_en=1: hour 23 and hour 3 → silent; hour 6 and hour 21 → chime. start==end → every hour chimes.
- cancel pulsed during the second beep of a 5-beep sequence → buzz=0 and busy=0 one cycle later, and no further beeps.
- Edge cases:
  - rst_n low mid-OFF → outputs clear immediately.
  - minute=0, second=0 without sec_tick → no trigger.
  - hour=25 → no trigger.
